// File: rtl/led_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : led_ctrl                                                       |
// | Purpose  : Multi-channel debug LED controller. Four display modes picked   |
// |            by mode_i: off, cascaded blink, PWM dimming, rotating chaser.  |
// |            The PWM duty is stepped up/down by two debounced push-buttons. |
// | Ports    : sys_clk  - system clock                                        |
// |            sys_rst  - asynchronous active-high reset                      |
// |            key_n    - raw active-low buttons, [0]=duty up, [1]=duty down  |
// |            mode_i   - raw mode select (0 off,1 blink,2 pwm,3 chaser)      |
// |            led_o    - registered LED drive, NB_CH channels                |
// |            duty_o   - current duty register (debug)                       |
// | Config   : LED_CTRL_FAST_SIM_EN - when defined, SIM_TAP and SIM_DEB_W     |
// |            replace TAP and DEB_W so blink/debounce times are short.       |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module led_ctrl #(
   parameter int NB_CH     = 8,
   parameter int CNT_W     = 27,
   parameter int TAP       = 26,
   parameter int PWM_W     = 8,
   parameter int DUTY_STEP = 32,
   parameter int DEB_W     = 20,
   parameter int SIM_TAP   = 10,
   parameter int SIM_DEB_W = 4
) (
   input  logic             sys_clk,
   input  logic             sys_rst,
   input  logic [1:0]       key_n,
   input  logic [1:0]       mode_i,
   output logic [NB_CH-1:0] led_o,
   output logic [PWM_W-1:0] duty_o
);

`ifdef LED_CTRL_FAST_SIM_EN
   localparam int c_TAP   = SIM_TAP;
   localparam int c_DEB_W = SIM_DEB_W;
`else
   localparam int c_TAP   = TAP;
   localparam int c_DEB_W = DEB_W;
`endif

   localparam logic [PWM_W:0] c_STEP = (PWM_W+1)'(DUTY_STEP);
   localparam logic [PWM_W:0] c_MAX  = {1'b0, {PWM_W{1'b1}}};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       mode_s1_q, mode_s2_q;
   logic [1:0]       key_s1_q, key_s2_q;
   logic [PWM_W-1:0] duty_q, duty_d;
   logic [NB_CH-1:0] ch_q, ch_d;
   logic [NB_CH-1:0] led_q, led_d;

   logic [1:0]       w_press;
   logic [NB_CH-1:0] w_rot;
   logic [NB_CH-1:0] w_blink;
   logic             w_tick;
   logic             w_pwm_on;
   logic [PWM_W:0]   w_up;
   logic [PWM_W:0]   w_dn;
   logic             w_unused;

   // Counter bits above the blink tap are only there to keep the counter
   // width as configured; fold them so they are visibly consumed.
   assign w_unused = ^cnt_q;

   // -------------------------------------------------------------------------
   // Per-key debounce: the stable level only follows the synced input after
   // it has disagreed for a full 2^DEB_W cycles. A press is the registered
   // 1->0 transition of the stable level, so it lasts exactly one cycle.
   // -------------------------------------------------------------------------
   for (genvar k = 0; k < 2; k++) begin : g_deb
      logic               st_q, st_d, st_prev_q;
      logic [c_DEB_W-1:0] dc_q, dc_d;

      always_comb begin
         st_d = st_q;
         dc_d = '0;
         if (key_s2_q[k] != st_q) begin
            if (&dc_q) begin
               st_d = key_s2_q[k];
            end else begin
               dc_d = dc_q + 1'b1;
            end
         end
      end

      always_ff @(posedge sys_clk or posedge sys_rst) begin
         if (sys_rst) begin
            st_q      <= 1'b1;
            st_prev_q <= 1'b1;
            dc_q      <= '0;
         end else begin
            st_q      <= st_d;
            st_prev_q <= st_q;
            dc_q      <= dc_d;
         end
      end

      assign w_press[k] = st_prev_q & ~st_q;
   end

   // Chaser rotation; a single channel simply holds its bit.
   if (NB_CH == 1) begin : g_rot_single
      assign w_rot = ch_q;
   end else begin : g_rot_multi
      assign w_rot = {ch_q[NB_CH-2:0], ch_q[NB_CH-1]};
   end

   // Channel i taps one counter bit lower than channel i-1, doubling its rate.
   for (genvar i = 0; i < NB_CH; i++) begin : g_blink
      assign w_blink[i] = cnt_q[c_TAP-i];
   end

   assign w_tick   = &cnt_q[c_TAP-1:0];
   assign w_pwm_on = (cnt_q[PWM_W-1:0] < duty_q);

   // One extra bit so overflow/borrow is visible before saturating.
   assign w_up = {1'b0, duty_q} + c_STEP;
   assign w_dn = {1'b0, duty_q} - c_STEP;

   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      duty_d = duty_q;
      ch_d   = ch_q;
      led_d  = '0;

      // Simultaneous up and down events cancel out.
      case (w_press)
         2'b01:   duty_d = (w_up > c_MAX) ? {PWM_W{1'b1}} : w_up[PWM_W-1:0];
         2'b10:   duty_d = w_dn[PWM_W] ? '0 : w_dn[PWM_W-1:0];
         default: duty_d = duty_q;
      endcase

      // Rotation runs regardless of mode so the position tracks time.
      if (w_tick) begin
         ch_d = w_rot;
      end

      case (mode_s2_q)
         2'd1:    led_d = w_blink;
         2'd2:    led_d = {NB_CH{w_pwm_on}};
         2'd3:    led_d = ch_q;
         default: led_d = '0;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cnt_q     <= '0;
         mode_s1_q <= 2'd0;
         mode_s2_q <= 2'd0;
         key_s1_q  <= 2'b11;
         key_s2_q  <= 2'b11;
         duty_q    <= '0;
         ch_q      <= NB_CH'(1);
         led_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         mode_s1_q <= mode_i;
         mode_s2_q <= mode_s1_q;
         key_s1_q  <= key_n;
         key_s2_q  <= key_s1_q;
         duty_q    <= duty_d;
         ch_q      <= ch_d;
         led_q     <= led_d;
      end
   end

   assign led_o  = led_q;
   assign duty_o = duty_q;

endmodule
`default_nettype wire

// File: tb/tb_led_ctrl.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module   : tb_led_ctrl                                                    |
// | Purpose  : Directed self-checking bench for led_ctrl with short blink and |
// |            debounce periods (tap 10, debounce width 4).                  |
// | Revision : 1.0 - initial release                                          |
// +---------------------------------------------------------------------------+
module tb_led_ctrl;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [1:0] key_n   = 2'b11;
   logic [1:0] mode_i  = 2'd2;
   logic [7:0] led_o;
   logic [7:0] duty_o;

   int err_cnt = 0;
   int chk_cnt = 0;
   int tbcnt;

   // Both TAP/DEB_W and their fast-sim substitutes are set to the short
   // values, so the bench behaves the same with or without the macro.
   led_ctrl #(
      .NB_CH(8), .CNT_W(27), .TAP(10), .PWM_W(8), .DUTY_STEP(32),
      .DEB_W(4), .SIM_TAP(10), .SIM_DEB_W(4)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .key_n  (key_n),
      .mode_i (mode_i),
      .led_o  (led_o),
      .duty_o (duty_o)
   );

   always #5 sys_clk = ~sys_clk;

   // Cycles since reset release; equals the free-running counter value.
   always @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) tbcnt <= 0;
      else         tbcnt <= tbcnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic nclk(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   // Hold the masked keys low for len cycles, then release and let the
   // release debounce settle.
   task automatic press(input logic [1:0] mask, input int len);
      key_n = ~mask;
      nclk(len);
      key_n = 2'b11;
      nclk(25);
   endtask

   function automatic logic [7:0] blink_exp(input int c);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[i] = c[10-i];
      return r;
   endfunction

   function automatic logic [7:0] chase_exp(input int c);
      int p;
      p = (c / 1024) % 8;
      return 8'(1 << p);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, t7, bad, ones, steps, last_chg;
      logic [7:0] prev, start_val;
      int e;

      // ---- 1: reset ----
      nclk(3);
      chk("rst_led", led_o, 0);
      chk("rst_duty", duty_o, 0);
      sys_rst = 1'b0;
      nclk(1);
      chk("post_rst_led", led_o, 0);

      // ---- 2: blink, with the mode edge placed so channel 7 is lit first ----
      for (int g = 0; g < 64 && (tbcnt % 16) != 6; g++) nclk(1);
      chk("align", tbcnt % 16, 6);
      mode_i = 2'd1;
      nclk(2);
      chk("blink_pre", led_o, 0);
      nclk(1);
      chk("blink_first_b7", led_o[7], 1);
      chk("blink_first", led_o, blink_exp(tbcnt - 1));
      t0 = 0; t7 = 0; bad = 0;
      prev = led_o;
      for (int n = 0; n < 2048; n++) begin
         nclk(1);
         if (led_o[0] != prev[0]) t0++;
         if (led_o[7] != prev[7]) t7++;
         if (led_o != blink_exp(tbcnt - 1)) bad++;
         prev = led_o;
      end
      chk("blink_tog0", t0, 2);
      chk("blink_tog7", t7, 256);
      chk("blink_bad", bad, 0);

      // ---- 3: debounce and duty saturation ----
      press(2'b01, 10);
      chk("short_press", duty_o, 0);
      key_n = 2'b10;
      nclk(18);
      chk("press_lat_pre", duty_o, 0);
      nclk(1);
      chk("press_lat", duty_o, 32);
      nclk(11);
      key_n = 2'b11;
      nclk(25);
      chk("press_one", duty_o, 32);
      for (int k = 2; k <= 8; k++) begin
         press(2'b01, 30);
         e = (32 * k > 255) ? 255 : 32 * k;
         chk("duty_up", duty_o, e);
      end
      for (int k = 1; k <= 9; k++) begin
         press(2'b10, 30);
         e = (255 - 32 * k < 0) ? 0 : 255 - 32 * k;
         chk("duty_dn", duty_o, e);
      end

      // ---- 4: PWM at duty 64, then simultaneous keys ----
      press(2'b01, 30);
      press(2'b01, 30);
      chk("duty64", duty_o, 64);
      mode_i = 2'd2;
      nclk(4);
      ones = 0; bad = 0;
      for (int n = 0; n < 256; n++) begin
         nclk(1);
         if (led_o == 8'hFF) ones++;
         if (led_o != ((((tbcnt - 1) & 255) < 64) ? 8'hFF : 8'h00)) bad++;
      end
      chk("pwm_ones", ones, 64);
      chk("pwm_bad", bad, 0);
      press(2'b11, 30);
      chk("both_keys", duty_o, 64);

      // ---- 5: chaser ----
      mode_i = 2'd3;
      nclk(4);
      chk("chase_now", led_o, chase_exp(tbcnt - 1));
      start_val = led_o;
      prev = led_o;
      steps = 0; bad = 0; last_chg = -1;
      for (int n = 0; n < 8192; n++) begin
         nclk(1);
         if (led_o != prev) begin
            if (led_o != {prev[6:0], prev[7]}) bad++;
            if (last_chg >= 0 && (tbcnt - last_chg) != 1024) bad++;
            last_chg = tbcnt;
            steps++;
         end
         if (led_o != chase_exp(tbcnt - 1)) bad++;
         prev = led_o;
      end
      chk("chase_steps", steps, 8);
      chk("chase_bad", bad, 0);
      chk("chase_wrap", led_o, start_val);
      mode_i = 2'd0;
      nclk(4);
      chk("off", led_o, 0);
      nclk(3000);
      chk("off_hold", led_o, 0);
      mode_i = 2'd3;
      nclk(2);
      chk("chase_resume_pre", led_o, 0);
      nclk(1);
      chk("chase_resume", led_o, chase_exp(tbcnt - 1));

      // ---- 6: asynchronous reset during a debounce count ----
      key_n = 2'b10;
      nclk(10);
      #2 sys_rst = 1'b1;
      #1;
      chk("arst_duty", duty_o, 0);
      chk("arst_led", led_o, 0);
      nclk(2);
      sys_rst = 1'b0;
      nclk(12);
      key_n = 2'b11;
      nclk(30);
      chk("arst_no_event", duty_o, 0);
      press(2'b01, 30);
      chk("arst_fresh", duty_o, 32);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
`default_nettype wire
